// File: rtl/pc_sequencer.sv
// Program-counter / fetch controller for the 8-bit ISA: picks the next ROM address from opcode, format and ALU flags.
// Optional retired-instruction counter is built only when PC_SEQ_RETIRE_CNT_EN is defined.
module pc_sequencer #(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned START_PC = 0,
    parameter int unsigned MAX_PC   = 30
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic [3:0]      opcode,
    input  logic [1:0]      format,
    input  logic [PC_W-1:0] jmp_loc,
    input  logic            alu_eq,
    input  logic            alu_lt,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            halted,
    output logic            oob_err,
    output logic [31:0]     retired_cnt
);

    localparam int unsigned CNT_W = 32;

    localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);
    localparam logic [PC_W-1:0] MAX_ADDR   = PC_W'(MAX_PC);

    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;

    localparam logic [1:0] FMT_C = 2'b00;
    localparam logic [1:0] FMT_M = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_halted;
    logic            w_halted_nxt;
    logic            r_oob;
    logic            w_oob_nxt;

    logic            w_take_branch;
    logic            w_target_oob;
    logic            w_seq_oob;
    logic            w_retire;

    // Branch resolution; jmp_loc is only meaningful for C-format JMP and M-format branches
    always_comb begin
        w_take_branch = 1'b0;
        case (opcode)
            OP_JMP:  w_take_branch = (format == FMT_C);
            OP_BEQ:  w_take_branch = (format == FMT_M) && alu_eq;
            OP_BNE:  w_take_branch = (format == FMT_M) && !alu_eq;
            OP_BLT:  w_take_branch = (format == FMT_M) && alu_lt;
            default: w_take_branch = 1'b0;
        endcase
    end

    assign w_target_oob = (jmp_loc > MAX_ADDR);
    assign w_seq_oob    = (r_pc >= MAX_ADDR);
    assign w_retire     = (r_state == ST_RUN) && !stall && !reset;

    // Next-state and next-PC selection
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_halted_nxt = r_halted;
        w_oob_nxt    = r_oob;

        case (r_state)
            ST_IDLE: begin
                w_pc_nxt = START_ADDR;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_oob_nxt   = 1'b0;
                end
            end

            ST_RUN: begin
                if (!stall) begin
                    if (opcode == OP_HALT) begin
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                    end else if (w_take_branch) begin
                        if (w_target_oob) begin
                            w_state_nxt  = ST_HALTED;
                            w_halted_nxt = 1'b1;
                            w_oob_nxt    = 1'b1;
                        end else begin
                            w_pc_nxt = jmp_loc;
                        end
                    end else if (w_seq_oob) begin
                        // Falling off the end of the program: freeze at the last legal address
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                        w_oob_nxt    = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end

            ST_HALTED: begin
                if (start) begin
                    w_state_nxt  = ST_RUN;
                    w_pc_nxt     = START_ADDR;
                    w_halted_nxt = 1'b0;
                    w_oob_nxt    = 1'b0;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_pc_nxt     = START_ADDR;
                w_halted_nxt = 1'b0;
                w_oob_nxt    = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= START_ADDR;
            r_halted <= 1'b0;
            r_oob    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= w_halted_nxt;
            r_oob    <= w_oob_nxt;
        end
    end

    assign pc          = r_pc;
    assign fetch_valid = w_retire;
    assign halted      = r_halted;
    assign oob_err     = r_oob;

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired_cnt;
    logic             w_cnt_clr;

    assign w_cnt_clr = start && (r_state != ST_RUN);

    // Saturating count of retired instructions since the last start
    always_ff @(posedge clk) begin
        if (reset || w_cnt_clr) begin
            r_retired_cnt <= '0;
        end else if (w_retire && (r_retired_cnt != {CNT_W{1'b1}})) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign retired_cnt = r_retired_cnt;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table with hand-derived expectations, then random stimulus vs a behavioural model.
module tb_pc_sequencer;

    localparam int unsigned PC_W     = 16;
    localparam int unsigned START_PC = 0;
    localparam int unsigned MAX_PC   = 30;
    localparam longint      CNT_MAX  = 64'h0000_0000_FFFF_FFFF;

    localparam logic [3:0] NOP = 4'b0100;
    localparam logic [3:0] JMP = 4'b0010;
    localparam logic [3:0] BNE = 4'b1010;
    localparam logic [3:0] BEQ = 4'b1011;
    localparam logic [3:0] BLT = 4'b1100;
    localparam logic [3:0] HLT = 4'b1110;
    localparam logic [3:0] TBA = 4'b1111;

    localparam logic [1:0] FC = 2'b00;
    localparam logic [1:0] FI = 2'b01;
    localparam logic [1:0] FM = 2'b10;
    localparam logic [1:0] FX = 2'b11;

    typedef struct {
        logic            rst;
        logic            st;
        logic            stl;
        logic [3:0]      op;
        logic [1:0]      fmt;
        logic [PC_W-1:0] jl;
        logic            eq;
        logic            lt;
        logic            fv;
        logic [PC_W-1:0] pc;
        logic            h;
        logic            o;
        logic [31:0]     cnt;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            st;
    logic            stl;
    logic [3:0]      op;
    logic [1:0]      fmt;
    logic [PC_W-1:0] jl;
    logic            eq;
    logic            lt;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            halted;
    logic            oob_err;
    logic [31:0]     retired_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit     m_run;
    int     m_pc;
    bit     m_h;
    bit     m_o;
    longint m_cnt;

    vec_t vecs[$];

    pc_sequencer #(
        .PC_W    (PC_W),
        .START_PC(START_PC),
        .MAX_PC  (MAX_PC)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (st),
        .stall      (stl),
        .opcode     (op),
        .format     (fmt),
        .jmp_loc    (jl),
        .alu_eq     (eq),
        .alu_lt     (lt),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .halted     (halted),
        .oob_err    (oob_err),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic vec_t mk(input bit r, input bit s, input bit sl, input logic [3:0] o_p,
                                input logic [1:0] f, input int j, input bit e, input bit l,
                                input bit efv, input int epc, input bit eh, input bit eo, input int ec);
        vec_t v;
        v.rst = r;  v.st = s;  v.stl = sl; v.op = o_p; v.fmt = f;
        v.jl  = PC_W'(j); v.eq = e; v.lt = l;
        v.fv  = efv; v.pc = PC_W'(epc); v.h = eh; v.o = eo; v.cnt = 32'(ec);
        return v;
    endfunction

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef PC_SEQ_RETIRE_CNT_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    // One clock of the architectural rules: reset, start from idle/halted, then retire-or-stall
    function automatic void model_step();
        bit taken;
        int nxt;
        if (rst) begin
            m_run = 0; m_pc = START_PC; m_h = 0; m_o = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_pc = START_PC; m_h = 0; m_o = 0; m_cnt = 0;
            end
        end else if (!stl) begin
            m_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
            taken = (op == JMP && fmt == FC) ||
                    (fmt == FM && ((op == BEQ && eq) || (op == BNE && !eq) || (op == BLT && lt)));
            nxt = taken ? int'(jl) : m_pc + 1;
            if (op == HLT) begin
                m_run = 0; m_h = 1;
            end else if (nxt > int'(MAX_PC)) begin
                m_run = 0; m_h = 1; m_o = 1;
            end else begin
                m_pc = nxt;
            end
        end
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; st = v.st; stl = v.stl; op = v.op; fmt = v.fmt;
        jl  = v.jl;  eq = v.eq; lt = v.lt;
    endtask

    task automatic cycle_check(input string tag, input logic fv_e, input logic [PC_W-1:0] pc_e,
                               input logic h_e, input logic o_e, input logic [31:0] c_e);
        #1;
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'(fv_e));
        @(posedge clk);
        #1;
        chk({tag, " pc"}, 32'(pc), 32'(pc_e));
        chk({tag, " halted"}, 32'(halted), 32'(h_e));
        chk({tag, " oob_err"}, 32'(oob_err), 32'(o_e));
        chk({tag, " retired_cnt"}, retired_cnt, cnt_exp(c_e));
    endtask

    initial begin
        logic efv;
        rst = 1; st = 0; stl = 0; op = NOP; fmt = FI; jl = '0; eq = 0; lt = 0;
        m_run = 0; m_pc = START_PC; m_h = 0; m_o = 0; m_cnt = 0;

        //            rst st stl op   fmt jl  eq lt | fv pc  h  o  cnt
        vecs.push_back(mk(1, 0, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // reset
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // idle holds
        vecs.push_back(mk(0, 1, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // start
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  1, 1,  0, 0, 1));
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  1, 2,  0, 0, 2));
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  1, 3,  0, 0, 3));
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  1, 4,  0, 0, 4));
        vecs.push_back(mk(0, 0, 0, HLT, FC, 0,  0, 0,  1, 4,  1, 0, 5));   // halt at 4, five retired
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  0, 4,  1, 0, 5));   // halted holds
        vecs.push_back(mk(0, 1, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // restart from halted
        vecs.push_back(mk(0, 0, 0, JMP, FC, 13, 0, 0,  1, 13, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, BEQ, FM, 10, 1, 0,  1, 10, 0, 0, 2));   // BEQ taken
        vecs.push_back(mk(0, 0, 0, JMP, FC, 13, 0, 0,  1, 13, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, BEQ, FM, 10, 0, 0,  1, 14, 0, 0, 4));   // BEQ not taken
        vecs.push_back(mk(0, 0, 0, JMP, FC, 5,  0, 0,  1, 5,  0, 0, 5));
        vecs.push_back(mk(0, 0, 0, BNE, FM, 2,  0, 0,  1, 2,  0, 0, 6));   // BNE taken
        vecs.push_back(mk(0, 0, 0, JMP, FC, 6,  0, 0,  1, 6,  0, 0, 7));
        vecs.push_back(mk(0, 0, 0, BLT, FM, 20, 0, 0,  1, 7,  0, 0, 8));   // BLT not taken
        vecs.push_back(mk(0, 0, 0, BLT, FM, 8,  0, 1,  1, 8,  0, 0, 9));   // BLT taken
        vecs.push_back(mk(0, 0, 1, HLT, FC, 0,  0, 0,  0, 8,  0, 0, 9));   // stalled HALT ignored
        vecs.push_back(mk(0, 0, 1, HLT, FC, 0,  0, 0,  0, 8,  0, 0, 9));
        vecs.push_back(mk(0, 0, 1, HLT, FC, 0,  0, 0,  0, 8,  0, 0, 9));
        vecs.push_back(mk(0, 0, 0, HLT, FC, 0,  0, 0,  1, 8,  1, 0, 10));  // released
        vecs.push_back(mk(0, 1, 1, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // start beats stall
        vecs.push_back(mk(0, 0, 1, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // stall in first RUN cycle
        vecs.push_back(mk(0, 0, 0, JMP, FC, 29, 0, 0,  1, 29, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  1, 30, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, NOP, FX, 0,  0, 0,  1, 30, 1, 1, 3));   // run past MAX_PC
        vecs.push_back(mk(0, 0, 0, NOP, FI, 0,  0, 0,  0, 30, 1, 1, 3));   // sticky
        vecs.push_back(mk(0, 1, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // restart clears oob
        vecs.push_back(mk(0, 0, 0, JMP, FC, 40, 0, 0,  1, 0,  1, 1, 1));   // jump out of range
        vecs.push_back(mk(0, 1, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, JMP, FC, 12, 0, 0,  1, 12, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, BNE, FM, 3,  1, 0,  1, 13, 0, 0, 2));   // start ignored in RUN
        vecs.push_back(mk(0, 0, 0, JMP, FC, 12, 0, 0,  1, 12, 0, 0, 3));
        vecs.push_back(mk(1, 0, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));   // reset mid-run at 12
        vecs.push_back(mk(0, 0, 0, JMP, FC, 7,  0, 0,  0, 0,  0, 0, 0));   // idle ignores opcode
        vecs.push_back(mk(0, 1, 0, NOP, FI, 0,  0, 0,  0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, TBA, FX, 9,  0, 0,  1, 1,  0, 0, 1));   // TBA is a no-op
        vecs.push_back(mk(0, 0, 0, BEQ, FM, 31, 1, 0,  1, 1,  1, 1, 2));   // taken branch past MAX_PC

        foreach (vecs[i]) begin
            drive(vecs[i]);
            model_step();
            cycle_check($sformatf("v%0d", i), vecs[i].fv, vecs[i].pc, vecs[i].h, vecs[i].o, vecs[i].cnt);
        end

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 9) == 0);
            stl = ($urandom_range(0, 4) == 0);
            op  = 4'($urandom_range(0, 15));
            if (op == JMP) fmt = FC;
            else if (op == BEQ || op == BNE || op == BLT) fmt = FM;
            else fmt = 2'($urandom_range(0, 3));
            jl  = PC_W'($urandom_range(0, 36));
            eq  = 1'($urandom_range(0, 1));
            lt  = 1'($urandom_range(0, 1));
            efv = m_run && !stl && !rst;
            model_step();
            cycle_check($sformatf("r%0d", n), efv, PC_W'(m_pc), m_h, m_o, 32'(m_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch controller that sequences the instruction ROM for the 8-bit ISA.
- Each cycle it drives the PC into the ROM, then uses the decoded opcode, format, jump location and ALU compare flags to choose the next PC.
- It handles jump, conditional branch, halt and stall, and bounds the program to a legal address range.
- It sits between the ROM/decoder and the register-file/ALU control.

Parameters:
- PC_W, 16, width of the program counter.
- START_PC, 0, address loaded on reset and on every start.
- MAX_PC, 30, last legal instruction address; a sequential fetch past it is out-of-bounds.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins execution at START_PC.
- stall  input  1  holds PC; current instruction does not retire.
- opcode  input  4  decoded opcode of instruction at pc.
- format  input  2  decoded format (C=00, I=01, M=10, X=11).
- jmp_loc  input  PC_W  resolved branch/jump target for instruction at pc.
- alu_eq  input  1  compare result, operands equal.
- alu_lt  input  1  compare result, operand1 < operand2 (unsigned).
- pc  output  PC_W  address to instruction ROM.
- fetch_valid  output  1  high when instruction at pc retires this cycle.
- halted  output  1  HALT instruction reached.
- oob_err  output  1  sticky, execution ran past MAX_PC.
- retired_cnt  output  32  instructions retired since last start (optional feature).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, pc=START_PC, fetch_valid=0, halted=0, oob_err=0, retired_cnt=0.
- Reset mid-operation behaves the same: the next edge returns to IDLE with these values and discards any pending branch.
- States: IDLE, RUN, HALTED.
- IDLE:
  - fetch_valid=0, pc held at START_PC.
  - start=1 -> RUN on the next edge; pc=START_PC, oob_err cleared, retired_cnt cleared.
- RUN:
  - fetch_valid = !stall (combinational).
  - stall=1: pc, state and counters hold; opcode and flags are ignored, including HALT.
  - stall=0, next PC selection (first match wins):
    - opcode 1110 (HALT): pc holds, -> HALTED, halted=1 next cycle.
    - opcode 0010 (JMP): pc <= jmp_loc.
    - opcode 1011 (BEQ) and alu_eq: pc <= jmp_loc.
    - opcode 1010 (BNE) and !alu_eq: pc <= jmp_loc.
    - opcode 1100 (BLT) and alu_lt: pc <= jmp_loc.
    - otherwise: pc <= pc+1.
  - Untaken branches fall through to pc+1.
  - Opcode 1111 (TBA) is treated as a no-op, pc+1.
  - Out-of-bounds:
    - A sequential increment with pc==MAX_PC sets oob_err=1 and goes to HALTED with halted=1; pc holds at MAX_PC.
    - A taken jump/branch with jmp_loc > MAX_PC does the same; pc holds.
    - pc never exceeds MAX_PC, so no PC_W wrap-around is possible.
  - start while in RUN is ignored.
- Format rule: jmp_loc is used only when format is C (JMP) or M (branches); otherwise it is don't-care. A taken branch with format X is not possible.
- HALTED:
  - fetch_valid=0; pc and oob_err hold.
  - start=1 -> RUN at START_PC; halted and oob_err clear on that edge.
- Simultaneous events: reset beats start beats stall. start and stall together in IDLE: start is taken, then stall applies from the first RUN cycle.
- Latency: the new pc is visible one cycle after the retiring edge. There are no delay slots.

Optional Feature:
- Macro: PC_SEQ_RETIRE_CNT_EN.
- When defined: retired_cnt increments by 1 on every edge where fetch_valid=1, including the HALT instruction itself. It saturates at all-ones and clears on start or reset.
- When undefined: retired_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Straight-line run:
  - Stimulus: reset, start, opcodes 0100 x4, then 1110.
  - Required: pc 0,1,2,3,4 on successive cycles; halted=1 with pc=4; retired_cnt=5 when the macro is defined.
- Taken BEQ:
  - Stimulus: pc=13 with opcode 1011, alu_eq=1, jmp_loc=10.
  - Required: next pc=10.
  - Same with alu_eq=0: next pc=14.
- BNE/BLT:
  - BNE at pc=5, alu_eq=0, jmp_loc=2 -> pc=2.
  - BLT at pc=6, alu_lt=0 -> pc=7.
- Stall:
  - Stimulus: assert stall for 3 cycles at pc=8 while opcode=1110.
  - Required: pc stays 8, fetch_valid=0, not halted; after release, halted next cycle.
- Out-of-bounds:
  - Stimulus: pc reaches 30 with non-branch opcode.
  - Required: next cycle oob_err=1, halted=1, pc=30.
  - JMP with jmp_loc=40: same result.
- Reset mid-run and restart:
  - reset at pc=12: next cycle IDLE, pc=0, outputs at reset values.
  - start from HALTED: pc=0, halted=0, oob_err=0.
